// File: rtl/scan_bus_router.sv
// Scan-side request router: one read/write at a time, steered to a lane of the
// packed SRAM, one of NUM_REGS control registers, or the status word.

module scan_bus_router_lane #(
  parameter int DATA_W = 32
) (
  input  logic              acc_hit,
  input  logic              rd_hit,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] lane_wdata,
  output logic [DATA_W-1:0] lane_bweb,
  output logic [DATA_W-1:0] lane_rdata
);
  assign lane_wdata = acc_hit ? wdata : '0;
  assign lane_bweb  = acc_hit ? '0 : '1;
  assign lane_rdata = rd_hit ? rdata : '0;
endmodule

module scan_bus_router #(
  parameter int          ADDR_W    = 11,
  parameter int          DATA_W    = 32,
  parameter int          SRAM_W    = 128,
  parameter int          SRAM_AW   = 8,
  parameter int          NUM_REGS  = 4,
  parameter int          REG_IDX_W = 3,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       scan_ren,
  input  logic                       scan_wen,
  input  logic [ADDR_W-1:0]          scan_addr,
  input  logic [DATA_W-1:0]          scan_wdata,
  output logic [DATA_W-1:0]          scan_rdata,
  output logic                       scan_ready,
  output logic                       scan_err,
  output logic                       scan_busy,
  output logic                       sram_ren,
  output logic                       sram_wen,
  output logic [SRAM_AW-1:0]         sram_addr,
  output logic [SRAM_W-1:0]          sram_wdata,
  output logic [SRAM_W-1:0]          sram_bweb,
  input  logic [SRAM_W-1:0]          sram_rdata,
  input  logic                       sram_ready,
  output logic [NUM_REGS-1:0]        reg_ren,
  output logic [NUM_REGS-1:0]        reg_wen,
  output logic [DATA_W-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  input  logic [NUM_REGS-1:0]        reg_ready,
  input  logic [DATA_W-1:0]          status
);
  localparam int LANES  = SRAM_W / DATA_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW     = $clog2(TIMEOUT);
  localparam logic [REG_IDX_W-1:0] STAT_IDX = REG_IDX_W'(NUM_REGS);
  localparam logic [TW-1:0]        TO_LAST  = TW'(TIMEOUT - 1);

  if ((SRAM_W % DATA_W) != 0 || (LANES & (LANES - 1)) != 0 ||
      (SRAM_AW + LANE_W) > (ADDR_W - 1) || NUM_REGS >= (1 << REG_IDX_W) ||
      TIMEOUT < 2) begin : g_param_err
    $error("scan_bus_router: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_d;
  logic                  cap_wr, cap_wr_d, cap_sram, cap_sram_d;
  logic [LANE_W-1:0]     cap_lane, cap_lane_d;
  logic [NUM_REGS-1:0]   cap_oh, cap_oh_d;
  logic [TW-1:0]         tcnt, tcnt_d;
  logic                  sram_ren_d, sram_wen_d, ready_d, err_d;
  logic [SRAM_AW-1:0]    sram_addr_d;
  logic [SRAM_W-1:0]     sram_wdata_d, sram_bweb_d;
  logic [NUM_REGS-1:0]   reg_ren_d, reg_wen_d;
  logic [DATA_W-1:0]     reg_wdata_d, rdata_d;

  logic                  acc_msb, acc_both, acc_req, is_sram, is_reg, is_stat;
  logic [LANE_W-1:0]     acc_lane;
  logic [REG_IDX_W-1:0]  acc_idx;
  logic [NUM_REGS-1:0]   acc_oh;
  logic [LANES-1:0]      acc_hit, rd_hit;
  logic [LANES-1:0][DATA_W-1:0] lane_wdata, lane_bweb, lane_rdata;
  logic [DATA_W-1:0]     sram_sel, reg_sel;
  logic                  tgt_ready;

  assign acc_msb  = scan_addr[ADDR_W-1];
  assign acc_both = scan_ren & scan_wen;
  assign acc_req  = scan_ren | scan_wen;
  assign acc_lane = scan_addr[LANE_W-1:0];
  assign acc_idx  = scan_addr[REG_IDX_W-1:0];
  assign is_sram  = !acc_msb && !acc_both;
  assign is_reg   = acc_msb && !acc_both && (acc_idx < STAT_IDX);
  assign is_stat  = acc_msb && scan_ren && !scan_wen && (acc_idx == STAT_IDX);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) acc_oh[i] = (acc_idx == REG_IDX_W'(i));
    reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cap_oh[i]) reg_sel = reg_sel | reg_rdata[i*DATA_W +: DATA_W];
    sram_sel = '0;
    for (int i = 0; i < LANES; i++) sram_sel = sram_sel | lane_rdata[i];
  end

  // Write lanes follow the live address at acceptance; read lanes follow the
  // captured lane so a later address change cannot disturb the return data.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign acc_hit[g] = (acc_lane == LANE_W'(g));
    assign rd_hit[g]  = (cap_lane == LANE_W'(g));
    scan_bus_router_lane #(.DATA_W(DATA_W)) u_lane (
      .acc_hit    (acc_hit[g]),
      .rd_hit     (rd_hit[g]),
      .wdata      (scan_wdata),
      .rdata      (sram_rdata[g*DATA_W +: DATA_W]),
      .lane_wdata (lane_wdata[g]),
      .lane_bweb  (lane_bweb[g]),
      .lane_rdata (lane_rdata[g])
    );
  end

  assign tgt_ready = cap_sram ? sram_ready : |(reg_ready & cap_oh);
  assign scan_busy = (state != IDLE);

  always_comb begin
    state_d      = state;
    cap_wr_d     = cap_wr;
    cap_sram_d   = cap_sram;
    cap_lane_d   = cap_lane;
    cap_oh_d     = cap_oh;
    tcnt_d       = tcnt;
    sram_ren_d   = 1'b0;
    sram_wen_d   = 1'b0;
    reg_ren_d    = '0;
    reg_wen_d    = '0;
    sram_bweb_d  = '1;
    sram_addr_d  = sram_addr;
    sram_wdata_d = sram_wdata;
    reg_wdata_d  = reg_wdata;
    rdata_d      = scan_rdata;
    ready_d      = 1'b0;
    err_d        = 1'b0;
    case (state)
      IDLE: if (acc_req) begin
        cap_wr_d   = scan_wen;
        cap_sram_d = is_sram;
        cap_lane_d = acc_lane;
        cap_oh_d   = acc_oh;
        if (is_sram) begin
          state_d     = ISSUE;
          sram_ren_d  = scan_ren;
          sram_wen_d  = scan_wen;
          sram_addr_d = scan_addr[LANE_W +: SRAM_AW];
          if (scan_wen) begin
            sram_wdata_d = lane_wdata;
            sram_bweb_d  = lane_bweb;
          end
        end else if (is_reg) begin
          state_d   = ISSUE;
          reg_ren_d = scan_ren ? acc_oh : '0;
          reg_wen_d = scan_wen ? acc_oh : '0;
          if (scan_wen) reg_wdata_d = scan_wdata;
        end else begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = is_stat ? status : ERR_DATA;
          err_d   = !is_stat;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        if (tgt_ready) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = cap_wr ? '0 : (cap_sram ? sram_sel : reg_sel);
        end else if (tcnt == TO_LAST) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_wr     <= 1'b0;
      cap_sram   <= 1'b0;
      cap_lane   <= '0;
      cap_oh     <= '0;
      tcnt       <= '0;
      sram_ren   <= 1'b0;
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_bweb  <= '1;
      reg_ren    <= '0;
      reg_wen    <= '0;
      reg_wdata  <= '0;
      scan_rdata <= '0;
      scan_ready <= 1'b0;
      scan_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cap_wr     <= cap_wr_d;
      cap_sram   <= cap_sram_d;
      cap_lane   <= cap_lane_d;
      cap_oh     <= cap_oh_d;
      tcnt       <= tcnt_d;
      sram_ren   <= sram_ren_d;
      sram_wen   <= sram_wen_d;
      sram_addr  <= sram_addr_d;
      sram_wdata <= sram_wdata_d;
      sram_bweb  <= sram_bweb_d;
      reg_ren    <= reg_ren_d;
      reg_wen    <= reg_wen_d;
      reg_wdata  <= reg_wdata_d;
      scan_rdata <= rdata_d;
      scan_ready <= ready_d;
      scan_err   <= err_d;
    end
  end
endmodule

// File: doc/scan_bus_router.md
Name: scan_bus_router

Overview:
- Parametrised successor to the scan memory/register mux. Routes one scan-side request (read or write) to either the lane-packed SRAM or one of NUM_REGS control registers.
- Adds a transaction FSM, registered target strobes, binary register indexing, a captured read-lane select, a status read path, a ready timeout and an error response.
- Sits between the scan sync controller and the FFT SRAM and control registers.

Parameters:
ADDR_W, 11, scan address width; MSB=0 selects SRAM, MSB=1 selects the register space
DATA_W, 32, scan data width
SRAM_W, 128, SRAM word width; must be a power-of-two multiple of DATA_W; LANES=SRAM_W/DATA_W, LANE_W=clog2(LANES)
SRAM_AW, 8, SRAM word address width; SRAM_AW+LANE_W <= ADDR_W-1
NUM_REGS, 4, number of control-register channels
REG_IDX_W, 3, register index field width, taken from addr[REG_IDX_W-1:0]
TIMEOUT, 16, maximum WAIT cycles before an error response (>=2)
ERR_DATA, 32'hDEADBEEF, scan_rdata value returned on an error response

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
scan_ren  in  1  read request
scan_wen  in  1  write request
scan_addr  in  ADDR_W  request address
scan_wdata  in  DATA_W  write data
scan_rdata  out  DATA_W  response data; valid only while scan_ready=1
scan_ready  out  1  one-cycle response pulse
scan_err  out  1  error qualifier; valid only with scan_ready
scan_busy  out  1  high whenever the FSM is not in IDLE
sram_ren  out  1  SRAM read strobe
sram_wen  out  1  SRAM write strobe
sram_addr  out  SRAM_AW  SRAM word address
sram_wdata  out  SRAM_W  write data placed in the selected lane; all other bits 0
sram_bweb  out  SRAM_W  active-low bit write enable
sram_rdata  in  SRAM_W  SRAM read data
sram_ready  in  1  SRAM completion
reg_ren  out  NUM_REGS  per-register read strobe, one-hot
reg_wen  out  NUM_REGS  per-register write strobe, one-hot
reg_wdata  out  DATA_W  shared register write data
reg_rdata  in  NUM_REGS*DATA_W  flattened read data; channel i occupies [i*DATA_W +: DATA_W]
reg_ready  in  NUM_REGS  per-register completion
status  in  DATA_W  status word (e.g. fft_done at bit 0)

Behaviour:
- Decode:
  - SRAM: scan_addr[ADDR_W-1]=0. Lane = addr[LANE_W-1:0]; sram_addr = addr[LANE_W +: SRAM_AW].
  - Register: MSB=1 and idx = addr[REG_IDX_W-1:0] < NUM_REGS.
  - Status: MSB=1 and idx == NUM_REGS; read only.
  - Illegal: idx > NUM_REGS; a write to status; scan_ren and scan_wen asserted together.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: accepts a request when scan_ren|scan_wen. On acceptance it captures the address, data, lane, target and direction into registers.
  - SRAM or register target: go to ISSUE.
  - Status read or illegal request: go directly to RESP, with no target strobe.
- ISSUE (exactly 1 cycle):
  - Drives the single strobe for the captured target and direction.
  - sram_bweb is 0 only across the captured lane bits and all-ones elsewhere; it is all-ones on reads.
  - Then go to WAIT.
- WAIT:
  - Samples the selected target's ready. sram_ready is the target for SRAM; reg_ready[idx] is the target for a register.
  - On ready, capture the read data and go to RESP. For SRAM, capture sram_rdata[lane*DATA_W +: DATA_W] using the lane captured at acceptance. Writes capture 0.
  - A timeout counter is cleared on entry. If ready has not arrived after TIMEOUT cycles, go to RESP with error.
- RESP (exactly 1 cycle):
  - scan_ready=1 and scan_busy=1.
  - scan_rdata is the captured data, the status word sampled at acceptance, or ERR_DATA.
  - scan_err=1 for illegal requests and timeouts.
  - Then return to IDLE.
- Latency:
  - SRAM/register: accept at T, strobe at T+1, earliest ready at T+2, scan_ready at T+3.
  - Status/illegal: scan_ready at T+1.
- Ready conditions:
  - Requests arriving while scan_busy=1 are ignored; no queueing.
  - Ready inputs are ignored outside WAIT, including a late ready after a timeout.
  - Ready from a non-selected register is ignored.
- All outputs are registered except scan_busy, which may be a decode of state.
- Outside the ISSUE cycle, all strobes are 0, sram_bweb is all-ones, and the data/address outputs hold their last values.
- Reset (asynchronous, also mid-transaction):
  - State goes to IDLE.
  - All strobes, scan_ready, scan_err and scan_busy go to 0.
  - scan_rdata, sram_addr, sram_wdata, reg_wdata and the counters go to 0; sram_bweb goes to all-ones.
  - An in-flight transaction is abandoned with no response.
- Elaboration fails on a parameter that violates the SRAM_W or SRAM_AW rules.

Test Plan:
- SRAM write lanes: write 0xA5A5_0001 to addr 0x00B (word 2, lane 3) -> one ISSUE cycle with sram_wen=1, sram_addr=2, sram_wdata[127:96]=0xA5A50001, sram_bweb[127:96]=0 and all other bits 1. The model asserts sram_ready; scan_ready arrives 3 cycles after acceptance with scan_err=0.
- SRAM read lane capture: read addr 0x009 (word 2, lane 1) with sram_rdata=0x4444_3333_2222_1111_... and scan_addr changed to 0x00B after acceptance -> scan_rdata=lane-1 word, unaffected by the later address change.
- Register index: write 0x7 to addr 0x402, then read it back -> reg_wen=4'b0100 for 1 cycle and reg_wdata=0x7. The read returns reg_rdata channel 2; a reg_ready[0] pulse during WAIT is ignored.
- Status/illegal:
  - Read 0x404 with status=0x1 -> scan_ready at T+1, rdata=0x1.
  - Write 0x404, read 0x405, or ren+wen together -> scan_ready at T+1, scan_err=1, rdata=0xDEADBEEF, no strobes.
- Timeout: read reg 1, ready never asserted -> scan_ready exactly 16 WAIT cycles after ISSUE with scan_err=1. reg_ready[1] asserted 2 cycles later produces no response.
- Busy/reset:
  - A second request during WAIT is dropped.
  - rst_n pulled low in WAIT immediately clears scan_busy and sram_bweb returns to all-ones.
  - A post-reset read of 0x404 completes normally.
